// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, reads a combinational instruction memory,
// buffers fetched words in a small FIFO and hands {pc, instr} to decode.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e          state_q;
  logic [31:0]     pc_q;
  logic            halted_q;
  logic [31:0]     fetch_count_q;
  logic [CW-1:0]   count_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW-1:0]   wr_ptr_q;
  logic [31:0]     q_instr [DEPTH];
  logic [31:0]     q_pc    [DEPTH];

  logic pop;
  logic full;
  logic can_push;
  logic is_halt;
  logic fetching;
  logic push;

  // Redirect targets are word aligned; the low address bits are dropped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    pop      = (count_q != '0) && out_ready;
    full     = (count_q == CW'(DEPTH));
    can_push = !full || pop;
    is_halt  = (imem_instr == HALT_WORD);
    fetching = (state_q == StRun) && fetch_en && !redirect_valid;
    push     = fetching && !is_halt && can_push;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (redirect_valid) begin
      // Flush wins over any same-cycle push or pop.
      pc_q     <= {redirect_pc[31:2], 2'b00};
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      halted_q <= 1'b0;
      if (state_q == StHalt) begin
        state_q <= StRun;
      end
    end else begin
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push) begin
        q_instr[wr_ptr_q] <= imem_instr;
        q_pc[wr_ptr_q]    <= pc_q;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
        pc_q              <= pc_q + 32'd4;
        fetch_count_q     <= fetch_count_q + 32'd1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      case (state_q)
        StIdle: begin
          if (fetch_en) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (!fetch_en) begin
            state_q <= StIdle;
          end else if (is_halt) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end
        end
        StHalt: begin
          halted_q <= 1'b1;
        end
        default: begin
          state_q  <= StIdle;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign out_valid   = (count_q != '0);
  assign out_instr   = q_instr[rd_ptr_q];
  assign out_pc      = q_pc[rd_ptr_q];
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a vector table for the straight-line program plus
// hand-written sequences for backpressure, redirect, halt, pause and async reset.
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        halted;
  logic [31:0] fetch_count;

  logic [31:0] mem [64];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic        eh;
    logic [31:0] efc;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tbl [9];

  always #5 clk = ~clk;

  assign imem_instr = mem[imem_addr[7:2]];

  fetch_sequencer #(
    .RESET_PC (RST_PC),
    .DEPTH    (2),
    .HALT_WORD(HALT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .fetch_en      (fetch_en),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  // addi x0, x0, i -- distinct per word so a skipped or duplicated fetch shows up.
  function automatic logic [31:0] norm(input int i);
    return 32'h0000_0013 | (32'(i) << 20);
  endfunction

  task automatic load_prog(input int halt_idx);
    for (int i = 0; i < 64; i++) mem[i] = norm(i);
    if (halt_idx >= 0) mem[halt_idx] = HALT;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic step(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
    fetch_en       = fe;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic ev, input logic [31:0] epc, input logic eh,
                      input logic [31:0] efc, input logic [31:0] eaddr);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    chk({tag, ".halted"}, 32'(halted), 32'(eh));
    chk({tag, ".fetch_count"}, fetch_count, efc);
    chk({tag, ".imem_addr"}, imem_addr, eaddr);
    if (ev) begin
      chk({tag, ".out_pc"}, out_pc, epc);
      chk({tag, ".out_instr"}, out_instr, norm(int'(epc[7:2])));
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h00, 1'b0, 32'd0, 32'h00};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h00, 1'b0, 32'd1, 32'h04};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h04, 1'b0, 32'd2, 32'h08};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h08, 1'b0, 32'd3, 32'h0C};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0C, 1'b0, 32'd4, 32'h10};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0, 32'd5, 32'h14};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h14, 1'b0, 32'd6, 32'h18};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h00, 1'b1, 32'd6, 32'h18};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h00, 1'b1, 32'd6, 32'h18};

    // Straight-line program ending in the halt marker at 0x18.
    load_prog(6);
    do_reset();
    look("rst", 1'b0, 32'h0, 1'b0, 32'd0, RST_PC);
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].fe, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
      look($sformatf("prog[%0d]", i), tbl[i].ev, tbl[i].epc, tbl[i].eh, tbl[i].efc,
           tbl[i].eaddr);
    end

    // Backpressure: queue fills, pc holds, then drains in order.
    load_prog(-1);
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0); look("bp0", 1'b0, 32'h0, 1'b0, 32'd0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0); look("bp1", 1'b1, 32'h0, 1'b0, 32'd1, 32'h4);
    step(1'b1, 1'b0, 1'b0, 32'h0); look("bp2", 1'b1, 32'h0, 1'b0, 32'd2, 32'h8);
    step(1'b1, 1'b0, 1'b0, 32'h0); look("bp3", 1'b1, 32'h0, 1'b0, 32'd2, 32'h8);
    step(1'b1, 1'b0, 1'b0, 32'h0); look("bp4", 1'b1, 32'h0, 1'b0, 32'd2, 32'h8);
    step(1'b1, 1'b1, 1'b0, 32'h0); look("bp5", 1'b1, 32'h4, 1'b0, 32'd3, 32'hC);
    step(1'b1, 1'b1, 1'b0, 32'h0); look("bp6", 1'b1, 32'h8, 1'b0, 32'd4, 32'h10);

    // Redirect coinciding with push and pop, misaligned target.
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0);  look("rd0", 1'b0, 32'h0, 1'b0, 32'd0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);  look("rd1", 1'b1, 32'h0, 1'b0, 32'd1, 32'h4);
    step(1'b1, 1'b1, 1'b1, 32'h13); look("rd2", 1'b0, 32'h0, 1'b0, 32'd1, 32'h10);
    step(1'b1, 1'b1, 1'b0, 32'h0);  look("rd3", 1'b1, 32'h10, 1'b0, 32'd2, 32'h14);

    // Halt with one entry queued, drain, then redirect out of halt.
    load_prog(1);
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0); look("hl0", 1'b0, 32'h0, 1'b0, 32'd0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0); look("hl1", 1'b1, 32'h0, 1'b0, 32'd1, 32'h4);
    step(1'b1, 1'b0, 1'b0, 32'h0); look("hl2", 1'b1, 32'h0, 1'b1, 32'd1, 32'h4);
    step(1'b1, 1'b0, 1'b0, 32'h0); look("hl3", 1'b1, 32'h0, 1'b1, 32'd1, 32'h4);
    step(1'b1, 1'b1, 1'b0, 32'h0); look("hl4", 1'b0, 32'h0, 1'b1, 32'd1, 32'h4);
    mem[1] = norm(1);
    step(1'b1, 1'b1, 1'b1, 32'h4); look("hl5", 1'b0, 32'h0, 1'b0, 32'd1, 32'h4);
    step(1'b1, 1'b1, 1'b0, 32'h0); look("hl6", 1'b1, 32'h4, 1'b0, 32'd2, 32'h8);

    // Pause at pc 0x8, then resume.
    load_prog(-1);
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0); look("pa0", 1'b0, 32'h0, 1'b0, 32'd0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0); look("pa1", 1'b1, 32'h0, 1'b0, 32'd1, 32'h4);
    step(1'b1, 1'b1, 1'b0, 32'h0); look("pa2", 1'b1, 32'h4, 1'b0, 32'd2, 32'h8);
    step(1'b0, 1'b0, 1'b0, 32'h0); look("pa3", 1'b1, 32'h4, 1'b0, 32'd2, 32'h8);
    step(1'b0, 1'b0, 1'b0, 32'h0); look("pa4", 1'b1, 32'h4, 1'b0, 32'd2, 32'h8);
    step(1'b1, 1'b1, 1'b0, 32'h0); look("pa5", 1'b0, 32'h0, 1'b0, 32'd2, 32'h8);
    step(1'b1, 1'b1, 1'b0, 32'h0); look("pa6", 1'b1, 32'h8, 1'b0, 32'd3, 32'hC);

    // Async reset mid-cycle while halted with a full queue.
    load_prog(2);
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0); look("ar0", 1'b0, 32'h0, 1'b0, 32'd0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0); look("ar1", 1'b1, 32'h0, 1'b0, 32'd1, 32'h4);
    step(1'b1, 1'b0, 1'b0, 32'h0); look("ar2", 1'b1, 32'h0, 1'b0, 32'd2, 32'h8);
    step(1'b1, 1'b0, 1'b0, 32'h0); look("ar3", 1'b1, 32'h0, 1'b1, 32'd2, 32'h8);
    #2 reset_n = 1'b0;
    #1;
    chk("arst.out_valid", 32'(out_valid), 32'd0);
    chk("arst.halted", 32'(halted), 32'd0);
    chk("arst.fetch_count", fetch_count, 32'd0);
    chk("arst.imem_addr", imem_addr, RST_PC);
    chk("arst.out_pc", out_pc, 32'h0);
    chk("arst.out_instr", out_instr, 32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
